ota_cal_seq: RTL and testbench

OTA_CAL_SEQ -- requirements
Module: ota_cal_seq

---
 rtl/ota_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/ota_cal_seq.sv | 151 +++++++++++++++
 tb/tb_ota_cal_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ota_ctrl_pkg.sv
// ota_ctrl_pkg
// Shared definitions for the OTA trim calibration sequencer: the FSM state
// encoding and the default trim width / settle length.
// No ports (package).
package ota_ctrl_pkg;

    // Calibration sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } cal_state_t;

    // Default trim DAC width.
    localparam int DEF_TRIM_W = 6;

    // Default settle cycles per trial (legal range 3..255).
    localparam int DEF_SETTLE_CYC = 16;

endpackage : ota_ctrl_pkg

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   in   destination clock, rising edge
//   rst_n in   asynchronous active-low reset (both flops clear to 0)
//   d     in   asynchronous input
//   q     out  synchronized output (two clk cycles of delay)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;
    logic stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            stable <= 1'b0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule : sync_2ff

// File: rtl/ota_cal_seq.sv
// ota_cal_seq
// Successive-approximation trim calibration for an OTA bias/offset DAC.
// Starting from the MSB-only code, each trim bit is tried in turn: the OTA
// is given SETTLE_CYC cycles to settle, then the synchronized comparator
// decides whether the bit stays (cmp=0) or is cleared (cmp=1, trim too high).
// A manual trim code can be loaded while idle.
//
// Handshake: start is a single-cycle request, accepted only in IDLE with
// ena=1; there is no backpressure. Completion is signalled by a one-cycle
// done pulse, at which point trim_out holds the result and cal_valid=1.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   tile enable; low aborts to IDLE
//   start     in   calibration request (IDLE only)
//   cmp_in    in   asynchronous comparator output, 1 = trim too high
//   man_load  in   load man_code into trim_out (IDLE only)
//   man_code  in   manual trim value
//   trim_out  out  registered trim code
//   busy      out  high in SETTLE and DECIDE
//   done      out  one-cycle completion pulse
//   cal_valid out  trim_out holds a completed calibration result
module ota_cal_seq
    import ota_ctrl_pkg::*;
#(
    parameter int TRIM_W     = DEF_TRIM_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              cmp_in,
    input  logic              man_load,
    input  logic [TRIM_W-1:0] man_code,
    output logic [TRIM_W-1:0] trim_out,
    output logic              busy,
    output logic              done,
    output logic              cal_valid
);

    localparam int                IDX_W       = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(TRIM_W - 1);
    localparam logic [TRIM_W-1:0] MSB_CODE    = TRIM_W'(1) << (TRIM_W - 1);
    // SETTLE_CYC is at most 255, so an 8-bit counter always suffices.
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);

    cal_state_t        state;
    logic [TRIM_W-1:0] trim_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              cmp_s;
    logic [TRIM_W-1:0] decide_code;

    // The comparator is only ever looked at after synchronization. The settle
    // window (>= 3 cycles) covers the two-flop delay, so the value seen in
    // DECIDE reflects the current trial code.
    sync_2ff u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_s)
    );

    // Trial resolution: drop the bit under test if the trim is too high,
    // and light the next lower bit as the following trial.
    always_comb begin
        decide_code = trim_q;
        if (cmp_s) begin
            decide_code[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
            decide_code[idx_q - IDX_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            trim_q  <= MSB_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            idx_q   <= IDX_TOP;
        end else if (!ena) begin
            // Abort: the trim code is frozen where it was, and a partially
            // calibrated code must not be reported as valid.
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (state != ST_IDLE) begin
                valid_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SETTLE;
                        trim_q  <= MSB_CODE;
                        idx_q   <= IDX_TOP;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (man_load) begin
                        trim_q  <= man_code;
                        valid_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state <= ST_DECIDE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DECIDE: begin
                    trim_q <= decide_code;
                    if (idx_q != '0) begin
                        idx_q <= idx_q - IDX_W'(1);
                        cnt_q <= 8'd0;
                        state <= ST_SETTLE;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign trim_out  = trim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cal_valid = valid_q;

endmodule : ota_cal_seq

// File: tb/tb_ota_cal_seq.sv
// tb_ota_cal_seq
// Self-checking bench for ota_cal_seq with TRIM_W=6, SETTLE_CYC=4 and a
// comparator model cmp_in = (trim_out > target).
module tb_ota_cal_seq;

    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 4;
    localparam int LAT        = 1 + TRIM_W * (SETTLE_CYC + 1);
    localparam logic [TRIM_W-1:0] MSB_CODE = TRIM_W'(1) << (TRIM_W - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              start = 1'b0;
    logic              cmp_in;
    logic              man_load = 1'b0;
    logic [TRIM_W-1:0] man_code = '0;
    logic [TRIM_W-1:0] trim_out;
    logic              busy;
    logic              done;
    logic              cal_valid;
    logic [TRIM_W-1:0] target = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [TRIM_W-1:0] exp_q[$];

    ota_cal_seq #(
        .TRIM_W     (TRIM_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .cmp_in    (cmp_in),
        .man_load  (man_load),
        .man_code  (man_code),
        .trim_out  (trim_out),
        .busy      (busy),
        .done      (done),
        .cal_valid (cal_valid)
    );

    // ---------------- clock / comparator model ----------------
    always #5 clk = ~clk;

    assign cmp_in = (trim_out > target);

    // Reference SAR: trim code after 'steps' decisions against tgt.
    function automatic logic [TRIM_W-1:0] sar_model(input logic [TRIM_W-1:0] tgt, input int steps);
        logic [TRIM_W-1:0] code;
        code = MSB_CODE;
        for (int k = 0; k < steps; k++) begin
            int b;
            b = TRIM_W - 1 - k;
            if (code > tgt) code[b] = 1'b0;
            if (b > 0) code[b-1] = 1'b1;
        end
        return code;
    endfunction

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver / scenario tasks ----------------

    // Runs one calibration. Optional disturbances: a second start at cycle
    // restart_at, a man_load at cycle mload_at, man_load together with start.
    task automatic run_cal(input logic [TRIM_W-1:0] tgt, input int restart_at,
                           input int mload_at, input bit mload_with_start, input string tag);
        int done_cyc;
        int done_cnt;
        int busy_cnt;
        logic [TRIM_W-1:0] want;
        target = tgt;
        exp_q.push_back(sar_model(tgt, TRIM_W));
        start = 1'b1;
        man_load = mload_with_start;
        man_code = ~tgt;
        tick();
        start = 1'b0;
        man_load = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy_on_start: got %b want 1", tag, busy); end
        tests_run++;
        if (trim_out !== MSB_CODE) begin tests_failed++; $display("FAIL %s_trim_on_start: got %0d want %0d", tag, trim_out, MSB_CODE); end
        tests_run++;
        if (cal_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_valid_on_start: got %b want 0", tag, cal_valid); end
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int n = 1; n <= LAT + 8; n++) begin
            if (n == restart_at) start = 1'b1;
            if (n == mload_at) begin man_load = 1'b1; man_code = ~tgt; end
            tick();
            start = 1'b0;
            man_load = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_unexpected_done: cycle %0d, no result expected", tag, n);
                end else begin
                    want = exp_q.pop_front();
                    if (trim_out !== want) begin tests_failed++; $display("FAIL %s_trim: got %0d want %0d", tag, trim_out, want); end
                end
                tests_run++;
                if (cal_valid !== 1'b1) begin tests_failed++; $display("FAIL %s_valid_at_done: got %b want 1", tag, cal_valid); end
            end
        end
        if (done_cnt == 0 && exp_q.size() != 0) void'(exp_q.pop_front());
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
        tests_run++;
        if (done_cyc != LAT) begin tests_failed++; $display("FAIL %s_latency: got %0d want %0d", tag, done_cyc, LAT); end
        tests_run++;
        if (busy_cnt != LAT - 1) begin tests_failed++; $display("FAIL %s_busy_cycles: got %0d want %0d", tag, busy_cnt, LAT - 1); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        #12;
        tests_run++;
        if (trim_out !== MSB_CODE || busy !== 1'b0 || done !== 1'b0 || cal_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got trim=%0d busy=%b done=%b valid=%b want trim=%0d busy=0 done=0 valid=0",
                     trim_out, busy, done, cal_valid, MSB_CODE);
        end
        rst_n = 1'b1;
        ena = 1'b1;
        tick();
        tick();
        tests_run++;
        if (trim_out !== MSB_CODE || busy !== 1'b0 || done !== 1'b0 || cal_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got trim=%0d busy=%b done=%b valid=%b", trim_out, busy, done, cal_valid);
        end
    endtask

    task automatic test_cal_basic();
        run_cal(6'd37, -1, -1, 1'b0, "cal37");
    endtask

    task automatic test_man_load();
        man_load = 1'b1;
        man_code = 6'd21;
        tick();
        man_load = 1'b0;
        tests_run++;
        if (trim_out !== 6'd21) begin tests_failed++; $display("FAIL man_load_trim: got %0d want 21", trim_out); end
        tests_run++;
        if (cal_valid !== 1'b0) begin tests_failed++; $display("FAIL man_load_valid: got %b want 0", cal_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL man_load_busy: got %b want 0", busy); end
    endtask

    task automatic test_cal_extremes();
        run_cal(6'd0, -1, -1, 1'b0, "cal0");
        run_cal(6'd63, -1, -1, 1'b0, "cal63");
    endtask

    task automatic test_busy_ignores();
        run_cal(6'd45, 10, 15, 1'b0, "busy_ignore");
    endtask

    task automatic test_start_priority();
        run_cal(6'd12, -1, -1, 1'b1, "start_wins");
    endtask

    task automatic test_ena_abort();
        int done_cnt;
        logic [TRIM_W-1:0] frozen;
        target = 6'd20;
        frozen = sar_model(6'd20, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 11; n++) tick();
        ena = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || cal_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got busy=%b done=%b valid=%b want 0 0 0", busy, done, cal_valid);
        end
        tests_run++;
        if (trim_out !== frozen) begin tests_failed++; $display("FAIL abort_trim_frozen: got %0d want %0d", trim_out, frozen); end
        start = 1'b1;
        man_load = 1'b1;
        man_code = 6'd7;
        tick();
        start = 1'b0;
        man_load = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || trim_out !== frozen) begin
            tests_failed++;
            $display("FAIL ena_low_ignores: got busy=%b trim=%0d want busy=0 trim=%0d", busy, trim_out, frozen);
        end
        ena = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        target = 6'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 13; n++) tick();
        tests_run++;
        if (trim_out !== sar_model(6'd50, 2) || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got trim=%0d busy=%b want trim=%0d busy=1", trim_out, busy, sar_model(6'd50, 2));
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (trim_out !== MSB_CODE || busy !== 1'b0 || done !== 1'b0 || cal_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got trim=%0d busy=%b done=%b valid=%b want trim=%0d 0 0 0",
                     trim_out, busy, done, cal_valid, MSB_CODE);
        end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        done_cnt = 0;
        tick();
        tests_run++;
        if (trim_out !== MSB_CODE || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got trim=%0d busy=%b", trim_out, busy);
        end
        for (int n = 0; n < LAT + 4; n++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin tests_failed++; $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_cal(TRIM_W'($urandom_range(0, (1 << TRIM_W) - 1)), -1, -1, 1'b0, "b2b");
        end
    endtask

    // ---------------- sequence / final report ----------------
    initial begin
        test_reset();
        test_cal_basic();
        test_man_load();
        test_cal_extremes();
        test_busy_ignores();
        test_start_priority();
        test_ena_abort();
        test_reset_mid();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ota_cal_seq
